adcsnap_trig_ctrl: RTL
======================

# adcsnap_trig_ctrl

Trigger-and-capture controller for the ADC snapshot path. Consumes the software-written trigger-offset and control words (both already in the `user_clk` domain, delivered by the OPB-to-fabric registers) together with the ADC sample stream. On an armed trigger it skips a programmed number of valid samples, then writes a fixed-length burst into the snapshot BRAM. Completion and fill count are reported back to software through a status word.

## Interface
- `ADDR_W`, default 10: BRAM address width; capture length is 2^ADDR_W samples.
- `DATA_W`, default 64: sample width.

- `user_clk`, input, 1: sole clock.
- `user_rst`, input, 1: synchronous reset, active-high.
- `ctrl_in`, input, 32: software control word.
  - bit0 `arm`: rising edge arms the controller.
  - bit1 `soft_trig`: level trigger, ORed with `trig`.
  - All other bits ignored.
- `trig_offset`, input, 32: unsigned post-trigger delay, in valid samples.
- `din`, input, DATA_W: ADC sample.
- `we`, input, 1: `din` is valid this cycle.
- `trig`, input, 1: hardware trigger, qualified by `we`.
- `bram_addr`, output, ADDR_W: BRAM write address.
- `bram_din`, output, DATA_W: BRAM write data.
- `bram_we`, output, 1: BRAM write strobe.
- `status_out`, output, 32: status word to software.
  - bit31 `done`.
  - bit30 `armed`: state is ARMED or DELAY.
  - bits[ADDR_W:0] `count`: samples written.
  - All other bits 0.

## Operation
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- Arm edge: detected by registering `ctrl_in[0]` (1-cycle edge detector). An edge in any state goes to ARMED and clears `count`, `done` and the address.
  - This includes restarting an in-progress DELAY or CAPTURE.
  - An edge takes priority over any trigger or write in the same cycle.
- ARMED: a trigger event is `we & (trig | ctrl_in[1])`.
  - `trig` with `we=0` is ignored.
  - On the event, `trig_offset` is latched. Later register changes have no effect until the next arm.
  - The trigger sample is index 0.
  - Offset 0: the trigger sample is written at address 0 and the state goes to CAPTURE.
  - Offset > 0: load the delay counter with the offset and go to DELAY.
- DELAY: each `we` decrements the counter. The `we` cycle that decrements it from 1 to 0 writes that sample at address 0 and enters CAPTURE.
  - Net effect: the first stored sample is valid-sample index `trig_offset` relative to the trigger.
- CAPTURE: each `we` writes `din` at the current address, then increments address and `count`.
  - Writing address 2^ADDR_W−1 ends the burst: go to DONE with `count` = 2^ADDR_W.
  - The address never wraps inside a burst.
- DONE: `done`=1. Stays here until a new arm edge or reset; no writes occur.
- IDLE: reached only from reset. Triggers are ignored.
- Offset arithmetic: the 32-bit offset uses a 32-bit down-counter. Offset 0xFFFFFFFF is legal; no overflow path exists.

## Timing
- Reset values:
  - state IDLE; `bram_addr`=0, `bram_din`=0, `bram_we`=0.
  - `status_out`=0; edge-detect register 0.
- All outputs are registered. `bram_we`/`bram_addr`/`bram_din` for a sample appear 1 cycle after the cycle in which that sample's `we` was high.
- `count` and `done` update in the same cycle as the corresponding `bram_we`.
  - The final write and `done`=1 are coincident.
- Arm edge to ARMED: `ctrl_in[0]` high at cycle N gives `armed`=1 at cycle N+2 (the extra cycle is the edge register).
- Triggers are accepted from the first ARMED cycle.
- Back-to-back `we` sustains one write per cycle. Gaps in `we` stall DELAY and CAPTURE without loss.
- Reset mid-burst: outputs go to reset values on the next edge and BRAM writes stop immediately. Partial BRAM contents are left as-is.

## Structure
- Package `adcsnap_pkg`:
  - state enum;
  - `CTRL_ARM_BIT`=0, `CTRL_SOFT_TRIG_BIT`=1;
  - `STAT_DONE_BIT`=31, `STAT_ARMED_BIT`=30.
- Sub-module `adcsnap_delay_cnt`: 32-bit loadable down-counter with `load`, `dec`, and `zero_next` outputs.
- The FSM, edge detect and BRAM output registers live in the top module.

## Test plan
- Reset, arm, `trig` with `we`=1 and offset 0, ramp `din`=0,1,2… → 1024 writes, addr 0..1023 holding 0..1023; `done`=1 with the last write; `count`=1024.
- Offset 5, trigger on sample value 100 → address 0 holds 105; `bram_we` first asserts 6 valid samples after the trigger.
- `we` toggling 1-0-1-0 during DELAY and CAPTURE → `bram_we` follows `we` with 1-cycle latency; no sample skipped or duplicated.
- `trig` pulsed with `we`=0 while armed, then `soft_trig` with `we`=1 → only the soft trigger starts capture.
- Re-arm edge at `count`=300 → `count` clears, state ARMED, next trigger writes from address 0.
- `user_rst` at `count`=500 → all outputs 0 next cycle; triggers ignored until an arm edge.

Source files
------------

// File: rtl/adcsnap_pkg.sv
// Shared types and bit positions for the ADC snapshot trigger/capture controller.
package adcsnap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int CTRL_ARM_BIT       = 0;
    localparam int CTRL_SOFT_TRIG_BIT = 1;
    localparam int STAT_DONE_BIT      = 31;
    localparam int STAT_ARMED_BIT     = 30;

    function automatic logic is_armed(state_t s);
        return (s == ST_ARMED) || (s == ST_DELAY);
    endfunction

endpackage

// File: rtl/adcsnap_trig_ctrl_if.sv
// BRAM write port of the snapshot path: the controller drives it, the BRAM consumes it.
interface adcsnap_trig_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              we;

    modport master (output addr, din, we);
    modport slave  (input  addr, din, we);
endinterface

// File: rtl/adcsnap_delay_cnt.sv
// 32-bit loadable down-counter for the post-trigger delay; zero_next flags that
// the next decrement lands on zero.
module adcsnap_delay_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        dec,
    output logic        zero_next
);
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    assign zero_next = (cnt_q == 32'd1);

endmodule

// File: rtl/adcsnap_trig_ctrl.sv
// Trigger-and-capture controller: arm on a rising ctrl bit, skip trig_offset valid
// samples after the trigger, then write a 2^ADDR_W sample burst into the snapshot BRAM.
module adcsnap_trig_ctrl
    import adcsnap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          ctrl_in,
    input  logic [31:0]          trig_offset,
    input  logic [DATA_W-1:0]    din,
    input  logic                 we,
    input  logic                 trig,
    adcsnap_trig_ctrl_if.master  bram,
    output logic [31:0]          status_out
);
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               arm_q, edge_q;
    logic               wr;
    logic               cnt_load, cnt_dec, zero_next;
    logic               trig_event;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  din_q;
    logic               we_q;
    logic [31:0]        status_q, status_d;

    // Control bits other than arm/soft_trig carry no meaning here.
    wire ctrl_unused = ^ctrl_in[31:2];

    assign trig_event = we & (trig | ctrl_in[CTRL_SOFT_TRIG_BIT]);

    adcsnap_delay_cnt u_delay_cnt (
        .clk       (user_clk),
        .rst       (user_rst),
        .load      (cnt_load),
        .load_val  (trig_offset),
        .dec       (cnt_dec),
        .zero_next (zero_next)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        wr       = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (edge_q) begin
            state_d = ST_ARMED;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_ARMED: begin
                    if (trig_event) begin
                        if (trig_offset == '0) begin
                            wr = 1'b1;
                        end else begin
                            cnt_load = 1'b1;
                            state_d  = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (we) begin
                        cnt_dec = 1'b1;
                        wr      = zero_next;
                    end
                end
                ST_CAPTURE: wr = we;
                default: ;
            endcase

            // The write address equals the running count, so the last slot ends the burst.
            if (wr) begin
                count_d = count_q + CNT_W'(1);
                state_d = (count_q[ADDR_W-1:0] == LAST_ADDR) ? ST_DONE : ST_CAPTURE;
            end
        end
    end

    always_comb begin
        status_d                 = '0;
        status_d[STAT_DONE_BIT]  = (state_d == ST_DONE);
        status_d[STAT_ARMED_BIT] = is_armed(state_d);
        status_d[ADDR_W:0]       = count_d;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            arm_q    <= 1'b0;
            edge_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            status_q <= '0;
        end else begin
            arm_q    <= ctrl_in[CTRL_ARM_BIT];
            edge_q   <= ctrl_in[CTRL_ARM_BIT] & ~arm_q;
            state_q  <= state_d;
            count_q  <= count_d;
            status_q <= status_d;
            we_q     <= wr;
            if (wr) begin
                addr_q <= count_q[ADDR_W-1:0];
                din_q  <= din;
            end else if (edge_q) begin
                addr_q <= '0;
            end
        end
    end

    assign bram.addr  = addr_q;
    assign bram.din   = din_q;
    assign bram.we    = we_q;
    assign status_out = status_q;

endmodule
